// File: rtl/data_pattern_pkg.sv
// rtl/data_pattern_pkg.sv - shared field layout, error classes and FSM encoding for the data pattern
package data_pattern_pkg;

  localparam int TDATA_W   = 512;
  localparam int FIELD_W   = 64;
  localparam int BEAT_LSB  = 0;
  localparam int PKT_LSB   = 64;
  localparam int NPKT_LSB  = 384;
  localparam int NBEAT_LSB = 448;

  localparam int NUM_ERR_CLASSES = 5;
  localparam int ERR_BEAT  = 0;
  localparam int ERR_PKT   = 1;
  localparam int ERR_NPKT  = 2;
  localparam int ERR_NBEAT = 3;
  localparam int ERR_TLAST = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [FIELD_W-1:0] get_field(input logic [TDATA_W-1:0] data, input int lsb);
    return data[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/beat_compare.sv
// rtl/beat_compare.sv - combinational compare of one received beat against the expected pattern
module beat_compare
  import data_pattern_pkg::*;
#(
  parameter int BEATS_LOG2 = 4
) (
  input  logic [TDATA_W-1:0]         i_tdata,
  input  logic                       i_tlast,
  input  logic [FIELD_W-1:0]         i_exp_beat,
  input  logic [FIELD_W-1:0]         i_exp_pkt,
  output logic [NUM_ERR_CLASSES-1:0] o_mismatch
);

  logic w_exp_last;

  assign w_exp_last = &i_exp_beat[BEATS_LOG2-1:0];

  always_comb begin
    o_mismatch            = '0;
    o_mismatch[ERR_BEAT]  = get_field(i_tdata, BEAT_LSB)  != i_exp_beat;
    o_mismatch[ERR_PKT]   = get_field(i_tdata, PKT_LSB)   != i_exp_pkt;
    o_mismatch[ERR_NPKT]  = get_field(i_tdata, NPKT_LSB)  != ~i_exp_pkt;
    o_mismatch[ERR_NBEAT] = get_field(i_tdata, NBEAT_LSB) != ~i_exp_beat;
    o_mismatch[ERR_TLAST] = i_tlast != w_exp_last;
  end

endmodule

// File: rtl/data_checker.sv
// rtl/data_checker.sv - receive-side pattern checker with packet/beat/error status
module data_checker
  import data_pattern_pkg::*;
#(
  parameter int BEATS_LOG2 = 4,
  parameter int ERR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [63:0]                packet_count,
  input  logic [TDATA_W-1:0]         AXIS_RX_TDATA,
  input  logic                       AXIS_RX_TVALID,
  input  logic                       AXIS_RX_TLAST,
  output logic                       AXIS_RX_TREADY,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [63:0]                packets_rcvd,
  output logic [63:0]                beats_rcvd,
  output logic [ERR_WIDTH-1:0]       error_count,
  output logic [NUM_ERR_CLASSES-1:0] error_flags,
  output logic [63:0]                first_error_beat
);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [63:0]                r_count;
  logic [63:0]                r_pkts;
  logic [63:0]                r_beats;
  logic [63:0]                r_exp_beat;
  logic [63:0]                r_exp_pkt;
  logic [63:0]                r_first;
  logic [ERR_WIDTH-1:0]       r_err_cnt;
  logic [NUM_ERR_CLASSES-1:0] r_flags;
  logic                       r_tready;
  logic                       r_done;
  logic                       r_pass;

  logic                       w_accept;
  logic [NUM_ERR_CLASSES-1:0] w_mismatch;
  logic                       w_any_err;
  logic [ERR_WIDTH-1:0]       w_err_next;
  logic                       w_last_pkt;

  beat_compare #(
    .BEATS_LOG2(BEATS_LOG2)
  ) u_beat_compare (
    .i_tdata   (AXIS_RX_TDATA),
    .i_tlast   (AXIS_RX_TLAST),
    .i_exp_beat(r_exp_beat),
    .i_exp_pkt (r_exp_pkt),
    .o_mismatch(w_mismatch)
  );

  assign w_accept   = r_tready & AXIS_RX_TVALID;
  assign w_any_err  = |w_mismatch;
  assign w_err_next = (w_any_err && r_err_cnt != '1)
                    ? r_err_cnt + {{(ERR_WIDTH-1){1'b0}}, 1'b1}
                    : r_err_cnt;
  assign w_last_pkt = w_accept & AXIS_RX_TLAST & ((r_pkts + 64'd1) == r_count);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // start always wins: it aborts a run even on the beat that would have completed it
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && packet_count != 64'd0) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start) begin
          w_next_state = (packet_count != 64'd0) ? ST_RUN : ST_IDLE;
        end else if (w_last_pkt) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy             = (r_state == ST_RUN);
    AXIS_RX_TREADY   = r_tready;
    done             = r_done;
    pass             = r_pass;
    packets_rcvd     = r_pkts;
    beats_rcvd       = r_beats;
    error_count      = r_err_cnt;
    error_flags      = r_flags;
    first_error_beat = r_first;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tready   <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_count    <= '0;
      r_pkts     <= '0;
      r_beats    <= '0;
      r_exp_beat <= '0;
      r_exp_pkt  <= '0;
      r_first    <= '1;
      r_err_cnt  <= '0;
      r_flags    <= '0;
    end else begin
      r_tready <= (w_next_state == ST_RUN);
      r_done   <= 1'b0;
      if (start) begin
        r_count    <= packet_count;
        r_pkts     <= '0;
        r_beats    <= '0;
        r_exp_beat <= '0;
        r_exp_pkt  <= '0;
        r_first    <= '1;
        r_err_cnt  <= '0;
        r_flags    <= '0;
        r_pass     <= (packet_count == 64'd0);
        r_done     <= (packet_count == 64'd0);
      end else if (w_accept) begin
        // expected values advance unconditionally; there is no resynchronisation
        r_beats    <= r_beats + 64'd1;
        r_exp_beat <= r_exp_beat + 64'd1;
        if (w_any_err) begin
          r_err_cnt <= w_err_next;
          r_flags   <= r_flags | w_mismatch;
          if (r_first == '1) begin
            r_first <= r_beats;
          end
        end
        if (AXIS_RX_TLAST) begin
          r_pkts    <= r_pkts + 64'd1;
          r_exp_pkt <= r_exp_pkt + 64'd1;
        end
        if (w_last_pkt) begin
          r_done <= 1'b1;
          r_pass <= (w_err_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_checker.sv
// tb/tb_data_checker.sv - self-checking bench for data_checker against a behavioural pattern model
module tb_data_checker;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [63:0]  packet_count;
  logic [511:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  logic         busy;
  logic         done;
  logic         pass;
  logic [63:0]  packets_rcvd;
  logic [63:0]  beats_rcvd;
  logic [31:0]  error_count;
  logic [4:0]   error_flags;
  logic [63:0]  first_error_beat;

  data_checker #(
    .BEATS_LOG2(4),
    .ERR_WIDTH (32)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .packet_count    (packet_count),
    .AXIS_RX_TDATA   (tdata),
    .AXIS_RX_TVALID  (tvalid),
    .AXIS_RX_TLAST   (tlast),
    .AXIS_RX_TREADY  (tready),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .packets_rcvd    (packets_rcvd),
    .beats_rcvd      (beats_rcvd),
    .error_count     (error_count),
    .error_flags     (error_flags),
    .first_error_beat(first_error_beat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int ds0 = 0;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  logic [63:0] m_count;
  logic [63:0] m_beats;
  logic [63:0] m_pkts;
  logic [63:0] m_first;
  int          m_errs;
  logic [4:0]  m_flags;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic [63:0] count);
    m_count = count;
    m_beats = '0;
    m_pkts  = '0;
    m_first = '1;
    m_errs  = 0;
    m_flags = '0;
  endtask

  // The n-th accepted beat should carry n and the number of TLASTs seen so far.
  task automatic model_beat(input logic [511:0] d, input logic t);
    logic [4:0] mm;
    mm    = '0;
    mm[0] = d[63:0]    != m_beats;
    mm[1] = d[127:64]  != m_pkts;
    mm[2] = d[447:384] != ~m_pkts;
    mm[3] = d[511:448] != ~m_beats;
    mm[4] = t != ((m_beats % 16) == 15);
    if (mm != 0) begin
      m_errs++;
      m_flags = m_flags | mm;
      if (m_first == '1) m_first = m_beats;
    end
    m_beats = m_beats + 1;
    if (t) m_pkts = m_pkts + 1;
  endtask

  // mode 0 clean, 1 corrupt packet word of beat 20, 2 TLAST moved 15->16, 3 beat 5 skipped
  task automatic make_beat(input int k, input int mode, output logic [511:0] d, output logic t);
    logic [63:0] bf;
    logic [63:0] pf;
    logic [31:0] flip;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    bf = (mode == 3 && k >= 5) ? 64'(k + 1) : 64'(k);
    pf = 64'(k / 16);
    t  = (k % 16) == 15;
    if (mode == 2 && k == 15) t = 1'b0;
    if (mode == 2 && k == 16) t = 1'b1;
    d[63:0]    = bf;
    d[127:64]  = pf;
    d[447:384] = ~pf;
    d[511:448] = ~bf;
    if (mode == 1 && k == 20) begin
      flip = $urandom | 32'h1;
      d[127:64] = d[127:64] ^ {32'h0, flip};
    end
  endtask

  task automatic do_start(input logic [63:0] count);
    start        = 1'b1;
    packet_count = count;
    ds0          = done_seen;
    @(posedge clk); #1;
    start  = 1'b0;
    tvalid = 1'b0;
    model_clear(count);
  endtask

  task automatic stream(input int mode, input bit gaps, input int stop_after);
    logic [511:0] d;
    logic         t;
    int           k;
    bit           fin;
    k   = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin && (stop_after == 0 || k < stop_after); cyc++) begin
      make_beat(k, mode, d, t);
      tdata  = d;
      tlast  = t;
      tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (tvalid && tready) begin
        model_beat(d, t);
        k++;
        if (t && m_pkts == m_count) fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (stop_after == 0) chk("stream_complete", {63'b0, fin}, 64'd1);
  endtask

  task automatic final_check(input string tag);
    @(negedge clk);
    chk({tag, "_done"},   {63'b0, done},   64'd1);
    chk({tag, "_tready"}, {63'b0, tready}, 64'd0);
    chk({tag, "_busy"},   {63'b0, busy},   64'd0);
    chk({tag, "_pass"},   {63'b0, pass},   {63'b0, m_errs == 0});
    chk({tag, "_pkts"},   packets_rcvd,    m_pkts);
    chk({tag, "_beats"},  beats_rcvd,      m_beats);
    chk({tag, "_errcnt"}, {32'b0, error_count}, 64'(m_errs));
    chk({tag, "_flags"},  {59'b0, error_flags}, {59'b0, m_flags});
    chk({tag, "_first"},  first_error_beat, m_first);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_low"}, {63'b0, done}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_once"}, 64'(done_seen - ds0), 64'd1);
  endtask

  initial begin
    logic [511:0] d;
    logic         t;
    logic [63:0]  held;

    resetn = 1'b0; start = 1'b0; packet_count = '0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_tready", {63'b0, tready}, 64'd0);
    chk("rst_busy",   {63'b0, busy},   64'd0);
    chk("rst_done",   {63'b0, done},   64'd0);
    chk("rst_pass",   {63'b0, pass},   64'd0);
    chk("rst_pkts",   packets_rcvd,    64'd0);
    chk("rst_beats",  beats_rcvd,      64'd0);
    chk("rst_errcnt", {32'b0, error_count}, 64'd0);
    chk("rst_flags",  {59'b0, error_flags}, 64'd0);
    chk("rst_first",  first_error_beat, '1);
    @(posedge clk); #1;

    do_start(64'd3);
    @(negedge clk);
    chk("run_tready", {63'b0, tready}, 64'd1);
    chk("run_busy",   {63'b0, busy},   64'd1);
    @(posedge clk); #1;
    stream(0, 1'b0, 0);
    final_check("clean");

    do_start(64'd3);
    stream(0, 1'b1, 0);
    final_check("gaps");

    do_start(64'd3);
    stream(1, 1'b1, 0);
    final_check("corrupt");

    do_start(64'd3);
    stream(2, 1'b1, 0);
    final_check("tlast_move");

    do_start(64'd3);
    stream(3, 1'b1, 0);
    final_check("skip");

    do_start(64'd0);
    @(negedge clk);
    chk("zero_done",   {63'b0, done},   64'd1);
    chk("zero_pass",   {63'b0, pass},   64'd1);
    chk("zero_tready", {63'b0, tready}, 64'd0);
    chk("zero_busy",   {63'b0, busy},   64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("zero_done_low", {63'b0, done},   64'd0);
    chk("zero_tready2",  {63'b0, tready}, 64'd0);
    @(posedge clk); #1;

    held = beats_rcvd;
    tvalid = 1'b1;
    repeat (4) @(posedge clk);
    #1 tvalid = 1'b0;
    @(negedge clk);
    chk("idle_bp_beats",  beats_rcvd, held);
    chk("idle_bp_tready", {63'b0, tready}, 64'd0);
    @(posedge clk); #1;

    do_start(64'd2);
    stream(0, 1'b0, 10);
    make_beat(10, 0, d, t);
    tdata = d; tlast = t; tvalid = 1'b1;
    do_start(64'd1);
    @(negedge clk);
    chk("abort_beats",  beats_rcvd,        64'd0);
    chk("abort_first",  first_error_beat,  '1);
    chk("abort_tready", {63'b0, tready},   64'd1);
    chk("abort_busy",   {63'b0, busy},     64'd1);
    @(posedge clk); #1;
    stream(0, 1'b1, 0);
    final_check("restart");

    do_start(64'd3);
    stream(0, 1'b0, 5);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_beats",  beats_rcvd,       64'd0);
    chk("midrst_first",  first_error_beat, '1);
    chk("midrst_tready", {63'b0, tready},  64'd0);
    chk("midrst_busy",   {63'b0, busy},    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_checker.md
Name: data_checker

Overview:
Receive-side counterpart of the packet data generator. Consumes the 512-bit AXI-Stream test pattern, checks every beat against independently regenerated expected values, and reports packet/beat counts, error counts and the first failing beat. Sits at the far end of the Ethernet link under test, feeding status registers read by the control CPU.

Parameters:
BEATS_LOG2, 4, log2 of beats per packet; TLAST expected when expected beat counter[BEATS_LOG2-1:0] is all ones
ERR_WIDTH, 32, width of error_count; saturates at all ones

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse: latch packet_count, clear all status, begin checking
packet_count  in  64  number of packets expected for this run
AXIS_RX_TDATA  in  512  stream data
AXIS_RX_TVALID  in  1  stream valid
AXIS_RX_TLAST  in  1  stream last
AXIS_RX_TREADY  out  1  stream ready; registered
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when run completes
pass  out  1  high after done if error_count==0; cleared by start
packets_rcvd  out  64  packets accepted this run (TLAST beats)
beats_rcvd  out  64  beats accepted this run
error_count  out  ERR_WIDTH  number of beats with at least one mismatch
error_flags  out  5  sticky OR of mismatch classes
first_error_beat  out  64  beats_rcvd value of first failing beat; all ones if none

Behaviour:
- Reset: state IDLE; TREADY, busy, done, pass = 0; packets_rcvd, beats_rcvd, error_count, error_flags = 0; first_error_beat = all ones; expected counter/packet = 0.
- Expected beat layout: [63:0] = exp_beat; [127:64] = exp_pkt; [447:384] = ~exp_pkt; [511:448] = ~exp_beat; [383:128] ignored. TLAST expected iff exp_beat[BEATS_LOG2-1:0] all ones.
- Mismatch classes (error_flags bit): 0 beat word, 1 packet word, 2 inverted packet word, 3 inverted beat word, 4 TLAST misplaced (either direction).
- FSM states IDLE, RUN.
  - IDLE: TREADY=0. On start: latch packet_count, clear status, exp_beat=exp_pkt=0. If packet_count!=0, next state RUN, TREADY=1, busy=1. If 0: stay IDLE, done pulses next cycle, pass=1.
  - RUN: a beat is accepted when TVALID&TREADY. On accept (all updates at the same edge): beats_rcvd+1, exp_beat+1; compare performed combinationally on the accepted beat; if any mismatch: error_count+1 (saturating), error_flags |= mismatch, first_error_beat=beats_rcvd if still all ones. If received TLAST=1: packets_rcvd+1, exp_pkt+1.
  - Completion: the accepted beat with TLAST=1 that makes packets_rcvd equal latched count -> next cycle state IDLE, TREADY=0, busy=0, done=1 for one cycle, pass=(final error_count==0).
- No resynchronisation: expected values advance on every accepted beat regardless of errors; a dropped beat therefore errors every subsequent beat.
- Packet framing follows received TLAST (not expected), so a misplaced TLAST still terminates the packet count.
- start during RUN: abort current run, re-latch, clear status, restart at exp 0 in same cycle; the beat accepted that cycle (if any) is discarded; no done pulse for aborted run.
- Beats presented while IDLE are back-pressured (TREADY=0), never counted.
- Counters wrap at 2^64 (no saturation) except error_count.
- resetn low mid-run: immediate return to reset values at next edge.

Decomposition:
- Package data_pattern_pkg: field offsets (BEAT_LSB=0, PKT_LSB=64, NPKT_LSB=384, NBEAT_LSB=448), field width 64, error class bit indices, state encoding. Shared with the generator.
- Sub-module beat_compare: combinational; inputs tdata, tlast, exp_beat, exp_pkt; output 5-bit mismatch vector.

Test Plan:
- start with packet_count=3, generator pattern, TVALID always high -> 48 beats accepted, packets_rcvd=3, done pulse once, pass=1, error_count=0, first_error_beat all ones.
- Same run with random TVALID gaps -> identical final status; TREADY drops the cycle after the 48th beat.
- Corrupt bits [127:64] on beat 20 -> error_count=1, error_flags=5'b00010, first_error_beat=20, pass=0.
- Drop TLAST on beat 15 and insert it on beat 16 -> error_flags bit4 set, error_count=2, first_error_beat=15.
- Skip one beat at beat 5 -> every following beat mismatches; error_flags=5'b01001, first_error_beat=5.
- start with packet_count=0 -> done next cycle, pass=1, TREADY stays 0; start during RUN after 10 beats -> counters cleared, new run completes normally with no done for the aborted run.
